buf_seq: RTL

BUF_SEQ -- requirements
Module: buf_seq

---
 rtl/buf_seq_pkg.sv | 17 +
 rtl/tok_pipe.sv | 25 ++
 rtl/buf_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/buf_seq_pkg.sv
// Shared types and default latencies for the buffer sequencer.
package buf_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef logic [11:0] cnt_t;

  localparam int OUT_LAT_DEF = 3;
  localparam int WB_LAT_DEF  = 5;
  localparam int TOK_W       = 13;

endpackage

// File: rtl/tok_pipe.sv
// Fixed-depth delay line carrying {valid, oc} tokens out to the destination buffer.
module tok_pipe #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/buf_seq.sv
// Source-read / output-ready sequencer for the MAC buffer path.
// state | meaning
// IDLE  | waiting for run
// EXEC  | issuing source reads, one per non-bubble cycle
// DRAIN | letting MAC pipe and write-back finish
// FIN   | one-cycle done pulse
module buf_seq
  import buf_seq_pkg::*;
#(
  parameter int OUT_LAT = OUT_LAT_DEF,
  parameter int WB_LAT  = WB_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [11:0] ss_m1,
  input  logic [11:0] ds_m1,
  input  logic        acc,
  input  logic        src_bank,
  input  logic        dst_bank,
  input  logic        host_v,
  output logic        busy,
  output logic        done,
  output logic        exec,
  output logic [12:0] ia,
  output logic        init,
  output logic        outr,
  output logic        accr,
  output logic [12:0] oa
);

  localparam int DW = $clog2(OUT_LAT + WB_LAT + 1);
  localparam logic [DW-1:0] DRAIN_LD = DW'(OUT_LAT + WB_LAT - 1);

  state_t state, state_nx;
  cnt_t   ic, oc, ss_r, ds_r;
  logic   acc_r, sb_r, db_r;
  logic [DW-1:0] drain_cnt;

  logic issue, last_in, last_out;
  logic [TOK_W-1:0] tok_in, tok_out;

  assign issue    = (state == EXEC) && !host_v;
  assign last_in  = (ic == ss_r);
  assign last_out = (oc == ds_r);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (run) state_nx = EXEC;
      EXEC:    if (issue && last_in && last_out) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ic        <= '0;
      oc        <= '0;
      ss_r      <= '0;
      ds_r      <= '0;
      acc_r     <= 1'b0;
      sb_r      <= 1'b0;
      db_r      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      if (state == IDLE && run) begin
        ss_r  <= ss_m1;
        ds_r  <= ds_m1;
        acc_r <= acc;
        sb_r  <= src_bank;
        db_r  <= dst_bank;
        ic    <= '0;
        oc    <= '0;
      end else if (issue) begin
        if (last_in) begin
          ic <= '0;
          oc <= oc + 12'd1;
        end else begin
          ic <= ic + 12'd1;
        end
      end
      if (state == EXEC && state_nx == DRAIN) drain_cnt <= DRAIN_LD;
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // One token per completed output; its oc rides along to form oa.
  assign tok_in = {issue && last_in, oc};

  tok_pipe #(.DEPTH(OUT_LAT), .WIDTH(TOK_W)) u_tok_pipe (
    .clk   (clk),
    .reset (reset),
    .din   (tok_in),
    .dout  (tok_out)
  );

  // Outputs are forced low while reset is asserted, before the state register clears.
  assign busy = !reset && (state == EXEC || state == DRAIN);
  assign done = !reset && (state == FIN);
  assign exec = !reset && issue;
  assign ia   = exec ? {sb_r, ic} : '0;
  assign init = exec && (ic == '0);
  assign outr = !reset && tok_out[TOK_W-1];
  assign accr = outr && acc_r;
  assign oa   = outr ? {db_r, tok_out[11:0]} : '0;

endmodule
